// File: rtl/paddle_pkg.sv
// Paddle mode encoding and default paddle geometry/colour.
package paddle_pkg;
  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    TRACK    = 2'd1,
    MANUAL   = 2'd2,
    RECENTER = 2'd3
  } paddle_mode_t;

  localparam int          PADDLE_WIDTH  = 20;
  localparam int          PADDLE_HEIGHT = 100;
  localparam logic [11:0] PADDLE_COLOR  = 12'hfff;
endpackage

// File: rtl/vga_pkg.sv
// Display geometry shared by every stage of the vga_if pixel chain.
package vga_pkg;
  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;
endpackage

// File: rtl/vga_if.sv
// One stage of the pixel chain: raster counters, sync/blank strobes and rgb.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/paddle_motion_ctrl.sv
// Paddle vertical motion: tick divider, pending move, mode register, clamp.
// Define PADDLE_SPEEDUP_EN to double the step after 8 same-direction moves.
module paddle_motion_ctrl
  import paddle_pkg::*;
  import vga_pkg::*;
#(
  parameter int HEIGHT   = PADDLE_HEIGHT,
  parameter int STEP_DIV = 500000,
  parameter int STEP     = 1,
  parameter int DEADBAND = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  input  paddle_mode_t mode,
  input  logic [10:0]  ball_y_pos,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         vblnk,
  output logic [10:0]  y_position,
  output logic         centered
);
  localparam int Y_MAX    = VER_PIXELS - HEIGHT;
  localparam int Y_CENTER = Y_MAX / 2;
  localparam int CNT_W    = $clog2(STEP_DIV);

  function automatic logic signed [11:0] sat_pos(input logic signed [11:0] p);
    if (p < 0) return '0;
    if (p > signed'(12'(Y_MAX))) return signed'(12'(Y_MAX));
    return p;
  endfunction

  logic [CNT_W-1:0]   tick_cnt;
  logic               pending;
  paddle_mode_t       state;
  logic               tick, commit;
  logic [11:0]        c_b, c_p;
  logic               mv_up, mv_dn, fast;
  logic signed [11:0] cur, diff, step_sz, delta;
  logic [10:0]        pos_nxt;

  assign tick   = (tick_cnt == CNT_W'(STEP_DIV - 1));
  assign commit = pending & vblnk;

  always_comb begin
    c_b   = {1'b0, ball_y_pos};
    c_p   = {1'b0, y_position} + 12'(HEIGHT / 2);
    mv_up = 1'b0;
    mv_dn = 1'b0;
    case (state)
      TRACK: begin
        if (c_b > c_p + 12'(DEADBAND))      mv_dn = 1'b1;
        else if (c_b + 12'(DEADBAND) < c_p) mv_up = 1'b1;
      end
      MANUAL: begin
        mv_up = btn_up & ~btn_down;
        mv_dn = btn_down & ~btn_up;
      end
      default: ;
    endcase
  end

`ifdef PADDLE_SPEEDUP_EN
  logic [2:0]   run_cnt;
  logic         run_vld;
  logic         run_up;
  paddle_mode_t run_mode;

  // run_cnt==7 means eight moves already went this way; the next one is doubled
  assign fast = run_vld && (run_cnt == 3'd7) && (run_mode == state) &&
                ((mv_up && run_up) || (mv_dn && !run_up));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_cnt  <= '0;
      run_vld  <= 1'b0;
      run_up   <= 1'b0;
      run_mode <= HOLD;
    end else if (commit) begin
      if (mv_up || mv_dn) begin
        if (run_vld && (run_mode == state) && (run_up == mv_up))
          run_cnt <= (run_cnt == 3'd7) ? run_cnt : run_cnt + 3'd1;
        else
          run_cnt <= '0;
        run_vld  <= 1'b1;
        run_up   <= mv_up;
        run_mode <= state;
      end else begin
        run_cnt <= '0;
        run_vld <= 1'b0;
      end
    end
  end
`else
  assign fast = 1'b0;
`endif

  always_comb begin
    cur     = signed'({1'b0, y_position});
    diff    = signed'(12'(Y_CENTER)) - cur;
    step_sz = fast ? signed'(12'(2 * STEP)) : signed'(12'(STEP));
    delta   = '0;
    if (state == RECENTER) begin
      if (diff > step_sz)       delta = step_sz;
      else if (diff < -step_sz) delta = -step_sz;
      else                      delta = diff;
    end else if (mv_up) begin
      delta = -step_sz;
    end else if (mv_dn) begin
      delta = step_sz;
    end
    pos_nxt = 11'(sat_pos(cur + delta));
  end

  // moves only land during vblnk so the visible frame never tears
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt   <= '0;
      pending    <= 1'b0;
      state      <= HOLD;
      y_position <= 11'(Y_CENTER);
      centered   <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      pending  <= tick | (pending & ~vblnk);
      state    <= mode;
      if (commit) y_position <= pos_nxt;
      centered <= (state == RECENTER) && (y_position == 11'(Y_CENTER));
    end
  end
endmodule

// File: rtl/draw_paddle_ctrl.sv
// Paddle overlay stage: one-clock vga_if register with the paddle rectangle
// painted in; motion in paddle_motion_ctrl (PADDLE_SPEEDUP_EN selects speed-up).
module draw_paddle_ctrl
  import paddle_pkg::*;
  import vga_pkg::*;
#(
  parameter int          X_POS    = HOR_PIXELS - 50,
  parameter int          WIDTH    = PADDLE_WIDTH,
  parameter int          HEIGHT   = PADDLE_HEIGHT,
  parameter logic [11:0] COLOR    = PADDLE_COLOR,
  parameter int          STEP_DIV = 500000,
  parameter int          STEP     = 1,
  parameter int          DEADBAND = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  input  paddle_mode_t mode,
  input  logic [10:0]  ball_y_pos,
  input  logic         btn_up,
  input  logic         btn_down,
  output logic [10:0]  y_position,
  output logic         centered,
  vga_if.in            vga,
  vga_if.out           vga_out
);
  logic [11:0] h, v, y;
  logic        in_rect;

  paddle_motion_ctrl #(
    .HEIGHT   (HEIGHT),
    .STEP_DIV (STEP_DIV),
    .STEP     (STEP),
    .DEADBAND (DEADBAND)
  ) u_motion (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .ball_y_pos (ball_y_pos),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .vblnk      (vga.vblnk),
    .y_position (y_position),
    .centered   (centered)
  );

  always_comb begin
    h       = {1'b0, vga.hcount};
    v       = {1'b0, vga.vcount};
    y       = {1'b0, y_position};
    in_rect = (h >= 12'(X_POS)) && (h <= 12'(X_POS + WIDTH - 1)) &&
              (v >= y) && (v <= y + 12'(HEIGHT - 1));
  end

  // register stage: timing delayed one clock, rgb overlaid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vga_out.hcount <= '0;
      vga_out.vcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.hcount <= vga.hcount;
      vga_out.vcount <= vga.vcount;
      vga_out.hsync  <= vga.hsync;
      vga_out.vsync  <= vga.vsync;
      vga_out.hblnk  <= vga.hblnk;
      vga_out.vblnk  <= vga.vblnk;
      vga_out.rgb    <= in_rect ? COLOR : vga.rgb;
    end
  end
endmodule

// File: tb/tb_draw_paddle_ctrl.sv
// Directed bench for draw_paddle_ctrl: unit A (STEP=1) and unit B (STEP=7).
module tb_draw_paddle_ctrl;
  import paddle_pkg::*;

  localparam logic [11:0] BG = 12'h0a5;

  logic         clk = 1'b0;
  logic         rst_n;
  paddle_mode_t mode_a, mode_b;
  logic [10:0]  ball_y;
  logic         up_a, dn_a, up_b, dn_b;
  logic [10:0]  y_a, y_b;
  logic         cen_a, cen_b;
  int           checks = 0;
  int           errors = 0;

  vga_if vin ();
  vga_if vout_a ();
  vga_if vout_b ();

  always #5 clk = ~clk;

  draw_paddle_ctrl #(.STEP_DIV(4), .STEP(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .mode(mode_a), .ball_y_pos(ball_y),
    .btn_up(up_a), .btn_down(dn_a), .y_position(y_a), .centered(cen_a),
    .vga(vin), .vga_out(vout_a)
  );

  draw_paddle_ctrl #(.STEP_DIV(4), .STEP(7)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(mode_b), .ball_y_pos(ball_y),
    .btn_up(up_b), .btn_down(dn_b), .y_position(y_b), .centered(cen_b),
    .vga(vin), .vga_out(vout_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // several clocks outside blanking (a tick is certainly pending), then a 1-clk vblnk
  task automatic pulse();
    vin.vblnk = 1'b0;
    repeat (6) @(negedge clk);
    vin.vblnk = 1'b1;
    @(negedge clk);
    vin.vblnk = 1'b0;
  endtask

  task automatic move_to(input bit sel, input logic [10:0] target, input string tag);
    int          n;
    logic [10:0] y;
    n = 0;
    y = sel ? y_b : y_a;
    while (y != target && n < 1000) begin
      pulse();
      n++;
      y = sel ? y_b : y_a;
    end
    chk(tag, 32'(y), 32'(target));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [10:0] hv [6];
    logic [10:0] vv [6];
    logic [11:0] ev [6];
    logic [10:0] base;
    hv = '{11'd750, 11'd769, 11'd770, 11'd760, 11'd749, 11'd760};
    vv = '{11'd300, 11'd399, 11'd350, 11'd400, 11'd350, 11'd299};
    ev = '{12'hfff, 12'hfff, BG, BG, BG, BG};

    rst_n  = 1'b0;
    mode_a = HOLD;
    mode_b = HOLD;
    ball_y = 11'd0;
    {up_a, dn_a, up_b, dn_b} = 4'b0000;
    vin.hcount = 11'd123;
    vin.vcount = 11'd5;
    vin.hsync  = 1'b1;
    vin.vsync  = 1'b1;
    vin.hblnk  = 1'b1;
    vin.vblnk  = 1'b1;
    vin.rgb    = 12'habc;
    repeat (2) @(negedge clk);
    chk("rst_rgb",    32'(vout_a.rgb), 32'h0);
    chk("rst_hcount", 32'(vout_a.hcount), 32'h0);
    chk("rst_vcount", 32'(vout_a.vcount), 32'h0);
    chk("rst_hsync",  32'(vout_a.hsync), 32'h0);
    chk("rst_vblnk",  32'(vout_a.vblnk), 32'h0);
    chk("rst_y_a",    32'(y_a), 32'd250);
    chk("rst_y_b",    32'(y_b), 32'd250);
    chk("rst_cen_a",  32'(cen_a), 32'h0);

    rst_n = 1'b1;
    {vin.hsync, vin.vsync, vin.hblnk, vin.vblnk} = 4'b0000;
    vin.rgb = BG;

    // bring A to y=300 and check the overlay window edges
    mode_a = MANUAL;
    dn_a   = 1'b1;
    move_to(1'b0, 11'd300, "a_to_300");
    dn_a   = 1'b0;
    mode_a = HOLD;
    for (int i = 0; i < 6; i++) begin
      vin.hcount = hv[i];
      vin.vcount = vv[i];
      vin.hsync  = i[0];
      @(negedge clk);
      chk($sformatf("ovl_rgb%0d", i), 32'(vout_a.rgb), 32'(ev[i]));
      chk($sformatf("ovl_hcnt%0d", i), 32'(vout_a.hcount), 32'(hv[i]));
      chk($sformatf("ovl_hsync%0d", i), 32'(vout_a.hsync), 32'(i[0]));
    end
    vin.hsync = 1'b0;

    // TRACK: moves only during vblnk, ticks collapse, dead zone, clamp at 0
    mode_a = TRACK;
    ball_y = 11'd600;
    repeat (20) @(negedge clk);
    chk("trk_no_vblnk", 32'(y_a), 32'd300);
    pulse(); chk("trk_down1", 32'(y_a), 32'd301);
    pulse(); chk("trk_down2", 32'(y_a), 32'd302);
    ball_y = 11'd360; pulse(); chk("trk_dead_mid", 32'(y_a), 32'd302);
    ball_y = 11'd312; pulse(); chk("trk_dead_edge", 32'(y_a), 32'd302);
    ball_y = 11'd311; pulse(); chk("trk_up1", 32'(y_a), 32'd301);
    ball_y = 11'd0;
    move_to(1'b0, 11'd0, "trk_to_0");
    pulse(); chk("trk_clamp0", 32'(y_a), 32'd0);

    // MANUAL: bottom clamp and both-buttons
    mode_a = MANUAL;
    dn_a   = 1'b1;
    move_to(1'b0, 11'd500, "man_to_max");
    {up_a, dn_a} = 2'b10; pulse(); chk("man_up", 32'(y_a), 32'd499);
    {up_a, dn_a} = 2'b11; pulse(); chk("man_both", 32'(y_a), 32'd499);
    {up_a, dn_a} = 2'b01; pulse(); chk("man_down", 32'(y_a), 32'd500);
    pulse(); chk("man_clamp", 32'(y_a), 32'd500);
    {up_a, dn_a} = 2'b00;
    mode_a = HOLD;

    // RECENTER on B (STEP=7) from the top
    mode_b = MANUAL;
    up_b   = 1'b1;
    move_to(1'b1, 11'd0, "b_to_0");
    up_b   = 1'b0;
    mode_b = RECENTER;
    repeat (35) pulse();
    chk("rc_245", 32'(y_b), 32'd245);
    chk("rc_cen_early", 32'(cen_b), 32'h0);
    pulse();
    chk("rc_250", 32'(y_b), 32'd250);
    chk("rc_cen_lag", 32'(cen_b), 32'h0);
    @(negedge clk);
    chk("rc_cen_set", 32'(cen_b), 32'h1);
    pulse();
    chk("rc_no_overshoot", 32'(y_b), 32'd250);
    chk("rc_cen_a", 32'(cen_a), 32'h0);
    mode_b = HOLD;
    repeat (2) @(negedge clk);
    chk("rc_cen_hold", 32'(cen_b), 32'h0);

    // speed-up: 8 down moves, then the 9th
    mode_a = MANUAL;
    up_a   = 1'b1;
    move_to(1'b0, 11'd480, "spd_to_480");
    up_a = 1'b0;
    pulse(); chk("spd_idle", 32'(y_a), 32'd480);
    dn_a = 1'b1;
    repeat (8) pulse();
    chk("spd_8_single", 32'(y_a), 32'd488);
    pulse();
`ifdef PADDLE_SPEEDUP_EN
    base = 11'd490;
`else
    base = 11'd489;
`endif
    chk("spd_9th", 32'(y_a), 32'(base));
    dn_a = 1'b0;
    pulse(); chk("spd_release", 32'(y_a), 32'(base));
    dn_a = 1'b1;
    pulse(); chk("spd_restart", 32'(y_a), 32'(base + 11'd1));
    dn_a = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
